cpu_fsm_param: RTL

Parametrised control core for the switch/button calculator CPU. It detects power and send button edges, latches an instruction from the switches, and decodes it. It then executes on an internal register file, writes the result back, and hands the result to the LCD driver through a start/busy handshake. It sits between the board I/O (buttons, switches) and the LCD controller, replacing the fixed-width control FSM with configurable data width, register count and immediate width, plus overflow reporting and an LCD handshake.

---
 rtl/cpu_fsm_param.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_fsm_param.sv
// Control core for the switch/button calculator CPU: latches an instruction on a send press,
// executes it on an internal register file and hands the result to the LCD driver.
module cpu_fsm_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int IMM_W    = 7,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_power,
  input  logic              btn_send,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [IMM_W-1:0]  rs2_imm,
  input  logic              lcd_busy,
  output logic              lcd_start,
  output logic [2:0]        lcd_op,
  output logic [ADDR_W-1:0] lcd_rd,
  output logic [DATA_W-1:0] lcd_value,
  output logic              lcd_ovf,
  output logic              powered,
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    S_OFF      = 4'd0,
    S_INIT     = 4'd1,
    S_WAIT     = 4'd2,
    S_FETCH    = 4'd3,
    S_DECODE   = 4'd4,
    S_EXEC     = 4'd5,
    S_WB       = 4'd6,
    S_LCD_PREP = 4'd7,
    S_LCD_SHOW = 4'd8
  } state_t;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return DATA_W'($signed(imm));
  endfunction

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] d);
    return (a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // The product fits only if every bit above the result width repeats its sign bit.
  function automatic logic mul_ovf(input logic signed [2*DATA_W-1:0] p);
    return !((&p[2*DATA_W-1:DATA_W-1]) || !(|p[2*DATA_W-1:DATA_W-1]));
  endfunction

  state_t                    state;
  logic [ADDR_W-1:0]         clr_cnt;
  logic                      pwr_sync_p0, pwr_sync_p1, pwr_sync_p2;
  logic                      send_sync_p0, send_sync_p1, send_sync_p2;
  logic                      pwr_p, send_p, wb_en;

  logic signed [DATA_W-1:0]  rf [NUM_REGS];
  logic [2:0]                op_p0;
  logic [ADDR_W-1:0]         rd_p0, rs1_p0;
  logic [IMM_W-1:0]          imm_p0;
  logic signed [DATA_W-1:0]  opa_p1, opb_p1;
  logic signed [DATA_W-1:0]  res_p2;
  logic                      ovf_p2;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]   alu_res;
  logic                       alu_ovf;

  // Button synchronizers and rising-edge detectors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_sync_p0  <= 1'b0;
      pwr_sync_p1  <= 1'b0;
      pwr_sync_p2  <= 1'b0;
      send_sync_p0 <= 1'b0;
      send_sync_p1 <= 1'b0;
      send_sync_p2 <= 1'b0;
    end else begin
      pwr_sync_p0  <= btn_power;
      pwr_sync_p1  <= pwr_sync_p0;
      pwr_sync_p2  <= pwr_sync_p1;
      send_sync_p0 <= btn_send;
      send_sync_p1 <= send_sync_p0;
      send_sync_p2 <= send_sync_p1;
    end
  end

  assign pwr_p   = pwr_sync_p1 & ~pwr_sync_p2;
  assign send_p  = send_sync_p1 & ~send_sync_p2;
  assign wb_en   = (state == S_WB) && !pwr_p;
  assign state_o = state;

  // Fetch -> decode -> execute datapath stages
  always_ff @(posedge clk) begin
    if (state == S_FETCH) begin
      op_p0  <= opcode;
      rd_p0  <= rd;
      rs1_p0 <= rs1;
      imm_p0 <= rs2_imm;
    end
    if (state == S_DECODE) begin
      opa_p1 <= (op_p0 == OP_DISPLAY) ? rf[rd_p0] : rf[rs1_p0];
      opb_p1 <= (op_p0 == OP_ADD || op_p0 == OP_SUB) ? rf[imm_p0[ADDR_W-1:0]] : sext_imm(imm_p0);
    end
    if (state == S_EXEC) begin
      res_p2 <= alu_res;
      ovf_p2 <= alu_ovf;
    end
  end

  always_comb begin
    prod    = (2*DATA_W)'(opa_p1) * (2*DATA_W)'(opb_p1);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_p0)
      OP_LOAD: alu_res = opb_p1;
      OP_ADD, OP_ADDI: begin
        alu_res = opa_p1 + opb_p1;
        alu_ovf = add_ovf(opa_p1, opb_p1, alu_res);
      end
      OP_SUB, OP_SUBI: begin
        alu_res = opa_p1 - opb_p1;
        alu_ovf = sub_ovf(opa_p1, opb_p1, alu_res);
      end
      OP_MUL: begin
        alu_res = prod[DATA_W-1:0];
        alu_ovf = mul_ovf(prod);
      end
      OP_CLEAR: alu_res = '0;
      default:  alu_res = opa_p1;
    endcase
  end

  // Register file: INIT clears one entry per cycle, CLEAR wipes all in the WB cycle
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      rf[clr_cnt] <= '0;
    end else if (wb_en) begin
      if (op_p0 == OP_CLEAR) begin
        for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (op_p0 != OP_DISPLAY) begin
        rf[rd_p0] <= res_p2;
      end
    end
  end

  // Control FSM; a power press outside OFF aborts whatever is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_OFF;
      powered   <= 1'b0;
      lcd_start <= 1'b0;
      lcd_op    <= '0;
      lcd_rd    <= '0;
      lcd_value <= '0;
      lcd_ovf   <= 1'b0;
      clr_cnt   <= '0;
    end else if (pwr_p && state != S_OFF) begin
      state     <= S_OFF;
      powered   <= 1'b0;
      lcd_start <= 1'b0;
    end else begin
      lcd_start <= 1'b0;
      case (state)
        S_OFF: begin
          if (pwr_p) begin
            state   <= S_INIT;
            powered <= 1'b1;
            clr_cnt <= '0;
          end
        end
        S_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_REG) begin
            state     <= S_LCD_PREP;
            lcd_start <= 1'b1;
            lcd_op    <= OP_CLEAR;
            lcd_rd    <= '0;
            lcd_value <= '0;
            lcd_ovf   <= 1'b0;
          end
        end
        S_WAIT:     if (send_p) state <= S_FETCH;
        S_FETCH:    state <= S_DECODE;
        S_DECODE:   state <= S_EXEC;
        S_EXEC:     state <= S_WB;
        S_WB: begin
          state     <= S_LCD_PREP;
          lcd_start <= 1'b1;
          lcd_op    <= op_p0;
          lcd_rd    <= rd_p0;
          lcd_value <= res_p2;
          lcd_ovf   <= ovf_p2;
        end
        S_LCD_PREP: state <= S_LCD_SHOW;
        S_LCD_SHOW: if (!lcd_busy) state <= S_WAIT;
        default:    state <= S_OFF;
      endcase
    end
  end

endmodule
